// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM generator, pwm_capture and benches.
//   pwm_capture_state_t : capture FSM states
//   chunk_clks()        : clocks per duty-cycle LSB for a clock rate and code width
package pwm_pkg;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_capture_state_t;

    // One extra clock per chunk keeps a full period just above 1 second's worth
    // of clocks divided evenly, identical to the generator's rounding.
    function automatic int chunk_clks(input int clock, input int width);
        return clock / (2 ** width) + 1;
    endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: input conditioning for pwm_capture.
// Two-flop synchronizer, optional 3-sample glitch filter
// (macro PWM_CAPTURE_GLITCH_FILTER_EN), and rise/fall edge detector.
// Ports:
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   pin_i   : raw asynchronous PWM pin
//   level_o : conditioned input level
//   rise_o  : one-cycle pulse on a conditioned 0->1 transition
//   fall_o  : one-cycle pulse on a conditioned 1->0 transition
module pwm_in_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic       s1_q;
    logic       s2_q;
    logic       prev_q;
    logic       level;
    logic [2:0] fill_q;
    logic       ready;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Clocks until prev_q holds a level derived from real pin samples.
    localparam logic [2:0] FILL = 3'd6;

    logic h0_q;
    logic h1_q;
    logic filt_q;

    // The level only moves once three consecutive synchronized samples agree.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h0_q   <= 1'b0;
            h1_q   <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            h0_q <= s2_q;
            h1_q <= h0_q;
            if ((s2_q == h0_q) && (h0_q == h1_q)) begin
                filt_q <= s2_q;
            end
        end
    end

    assign level = filt_q;
`else
    localparam logic [2:0] FILL = 3'd3;

    assign level = s2_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            fill_q <= 3'd0;
        end else begin
            s1_q   <= pin_i;
            s2_q   <= s1_q;
            prev_q <= level;
            if (fill_q != FILL) begin
                fill_q <= fill_q + 3'd1;
            end
        end
    end

    // Edges are held off until the pipeline has flushed its reset zeros, so a
    // pin that is already high when reset releases does not look like a rise.
    assign ready   = (fill_q == FILL);
    assign level_o = level;
    assign rise_o  = ready & level & ~prev_q;
    assign fall_o  = ready & ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: decodes the high time of an incoming PWM signal into a
// WIDTH-bit duty code, rounded to the nearest generator chunk.
// Optional input glitch filter: PWM_CAPTURE_GLITCH_FILTER_EN.
// Ports:
//   clk        : system clock
//   clr        : asynchronous active-high reset
//   pwm_in     : asynchronous PWM input
//   duty_cycle : last decoded duty code (held between updates)
//   valid      : one-cycle strobe when duty_cycle updates
//   stuck      : high while the input has produced no edge for TIMEOUT_CLKS
//
// state | meaning
// ------+---------------------------------------------------------------
// WAIT  | after reset or timeout; ignore input until a rise
// HIGH  | measuring a high pulse; sub/chunk counters advance every clock
// LOW   | between pulses; counters held at zero
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CLOCK        = 50000000,
    parameter int WIDTH        = 8,
    parameter int CHUNK_CLKS   = chunk_clks(CLOCK, WIDTH),
    parameter int TIMEOUT_CLKS = 2 * (2 ** WIDTH) * CHUNK_CLKS
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             valid,
    output logic             stuck
);

    localparam int SUB_W = (CHUNK_CLKS > 1) ? $clog2(CHUNK_CLKS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [WIDTH-1:0] MAX       = '1;
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CHUNK_CLKS - 1);
    localparam logic [SUB_W-1:0] SUB_HALF  = SUB_W'(CHUNK_CLKS / 2);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

    logic level;
    logic rise;
    logic fall;

    pwm_in_sync u_sync (
        .clk_i   (clk),
        .rst_i   (clr),
        .pin_i   (pwm_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    pwm_capture_state_t state_q, state_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic [WIDTH-1:0]   chunk_q, chunk_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [WIDTH-1:0]   duty_q, duty_d;
    logic               valid_q, valid_d;
    logic               stuck_q, stuck_d;

    logic [SUB_W-1:0]   base_sub;
    logic [WIDTH-1:0]   base_chunk;
    logic [SUB_W-1:0]   adv_sub;
    logic [WIDTH-1:0]   adv_chunk;
    logic [WIDTH:0]     code_ext;
    logic [WIDTH-1:0]   code;
    logic               tmo_hit;

    // Counter advance. Outside HIGH the advance starts from zero, so the
    // cycle carrying the rise is already counted as the first high clock.
    always_comb begin
        base_sub   = (state_q == HIGH) ? sub_q   : '0;
        base_chunk = (state_q == HIGH) ? chunk_q : '0;
        adv_sub    = base_sub;
        adv_chunk  = base_chunk;
        if (base_sub == SUB_LAST) begin
            adv_sub   = '0;
            adv_chunk = (base_chunk == MAX) ? MAX : base_chunk + 1'b1;
        end else begin
            adv_sub = base_sub + 1'b1;
        end
    end

    // Round to the nearest chunk; rounding up from MAX stays at MAX.
    always_comb begin
        code_ext = {1'b0, chunk_q} + {{WIDTH{1'b0}}, (sub_q >= SUB_HALF)};
        code     = code_ext[WIDTH] ? MAX : code_ext[WIDTH-1:0];
    end

    // An edge in the same cycle always beats the timeout.
    assign tmo_hit = ~(rise | fall) && (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        chunk_d = chunk_q;
        duty_d  = duty_q;
        valid_d = 1'b0;
        stuck_d = stuck_q;
        tmo_d   = tmo_q;

        if (rise | fall) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_LIMIT) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            WAIT, LOW: begin
                sub_d   = '0;
                chunk_d = '0;
                if (rise) begin
                    state_d = HIGH;
                    sub_d   = adv_sub;
                    chunk_d = adv_chunk;
                    stuck_d = 1'b0;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = LOW;
                    duty_d  = code;
                    valid_d = 1'b1;
                    sub_d   = '0;
                    chunk_d = '0;
                end else begin
                    sub_d   = adv_sub;
                    chunk_d = adv_chunk;
                end
            end
            default: begin
                state_d = WAIT;
                sub_d   = '0;
                chunk_d = '0;
            end
        endcase

        // The counter parks at its limit, so this fires once per episode.
        if (tmo_hit) begin
            state_d = WAIT;
            sub_d   = '0;
            chunk_d = '0;
            duty_d  = level ? MAX : '0;
            valid_d = 1'b1;
            stuck_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= WAIT;
            sub_q   <= '0;
            chunk_q <= '0;
            tmo_q   <= '0;
            duty_q  <= '0;
            valid_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            chunk_q <= chunk_d;
            tmo_q   <= tmo_d;
            duty_q  <= duty_d;
            valid_q <= valid_d;
            stuck_q <= stuck_d;
        end
    end

    assign duty_cycle = duty_q;
    assign valid      = valid_q;
    assign stuck      = stuck_q;

endmodule
